// File: rtl/mem_pkg.sv
// Shared size encodings, FSM state encoding and byte-lane helpers for the MEM-stage access unit.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // A dword request on a 32-bit RAM degrades to a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] size, input logic dword_ok);
    return (size == SZ_DWORD && !dword_ok) ? SZ_WORD : size;
  endfunction

  function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] off);
    logic [2:0] low_mask;
    low_mask = (3'd1 << size) - 3'd1;
    return off & ~low_mask;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off_a);
    logic [8:0] run;
    run = (9'd1 << (4'd1 << size)) - 9'd1;
    return run[7:0] << off_a;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data alignment: shift the addressed lanes down, keep 1<<size bytes, zero/sign fill.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic [DATA_BITS-1:0]           rdata_i,
  input  logic [$clog2(DATA_BITS/8)-1:0] off_i,
  input  logic [1:0]                     size_i,
  input  logic                           signed_i,
  output logic [DATA_BITS-1:0]           data_o
);

  localparam int LANES = DATA_BITS / 8;

  logic [DATA_BITS-1:0] shifted;
  logic [DATA_BITS-1:0] keep_mask;
  logic [3:0]           nbytes;
  logic                 sign_bit;

  assign shifted = rdata_i >> {off_i, 3'b000};
  assign nbytes  = 4'd1 << size_i;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_keep
    assign keep_mask[8*gi +: 8] = (4'(gi) < nbytes) ? 8'hFF : 8'h00;
  end

  always_comb begin
    sign_bit = shifted[7];
    case (size_i)
      SZ_HALF:  sign_bit = shifted[15];
      SZ_WORD:  sign_bit = shifted[31];
      SZ_DWORD: sign_bit = shifted[DATA_BITS-1];
      default:  sign_bit = shifted[7];
    endcase
  end

  assign data_o = (shifted & keep_mask) | ((signed_i && sign_bit) ? ~keep_mask : '0);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer driving a byte-lane RAM port with an ack handshake.
// Optional build macro MISALIGN_TRAP_EN: misaligned requests skip the RAM and respond with misalign=1.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_signed,
  input  logic [31:0]            req_addr,
  input  logic [DATA_BITS-1:0]   req_wdata,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [ADDR_BITS-1:0]   ram_addr,
  output logic [DATA_BITS/8-1:0] ram_sel,
  output logic [DATA_BITS-1:0]   ram_wdata,
  input  logic [DATA_BITS-1:0]   ram_rdata,
  input  logic                   ram_ack,
  output logic                   resp_valid,
  output logic [DATA_BITS-1:0]   resp_rdata,
  output logic                   stall,
  output logic                   misalign
);

  localparam int LANES = DATA_BITS / 8;
  localparam int OFFS  = $clog2(LANES);

  state_e                 state_q;
  logic                   ram_en_q, ram_we_q, resp_valid_q, misalign_q;
  logic [ADDR_BITS-1:0]   ram_addr_q;
  logic [LANES-1:0]       ram_sel_q;
  logic [DATA_BITS-1:0]   ram_wdata_q, resp_rdata_q;
  logic [OFFS-1:0]        ld_off_q;
  logic [1:0]             ld_size_q;
  logic                   ld_signed_q;

  logic [1:0]             size_eff;
  logic [2:0]             off_full, off_a_full;
  logic [7:0]             sel_full;
  logic [ADDR_BITS-1:0]   ram_addr_d;
  logic [DATA_BITS-1:0]   ram_wdata_d;
  logic                   misalign_d;
  logic [DATA_BITS-1:0]   ld_data;
  logic                   unused_bits;

  assign size_eff    = eff_size(req_size, DATA_BITS == 64);
  assign off_full    = 3'(req_addr[OFFS-1:0]);
  assign off_a_full  = align_off(size_eff, off_full);
  assign sel_full    = lane_mask(size_eff, off_a_full);
  assign ram_addr_d  = ADDR_BITS'(req_addr >> OFFS);
  assign ram_wdata_d = req_wdata << {off_a_full[OFFS-1:0], 3'b000};
  assign unused_bits = ^sel_full;

`ifdef MISALIGN_TRAP_EN
  assign misalign_d = (off_full != off_a_full);
`else
  assign misalign_d = 1'b0;
`endif

  mem_load_align #(.DATA_BITS(DATA_BITS)) u_align (
    .rdata_i  (ram_rdata),
    .off_i    (ld_off_q),
    .size_i   (ld_size_q),
    .signed_i (ld_signed_q),
    .data_o   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_sel_q    <= '0;
      ram_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      misalign_q   <= 1'b0;
      ld_off_q     <= '0;
      ld_size_q    <= SZ_BYTE;
      ld_signed_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            ld_off_q    <= off_a_full[OFFS-1:0];
            ld_size_q   <= size_eff;
            ld_signed_q <= req_signed;
            if (misalign_d) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              misalign_q   <= 1'b1;
            end else begin
              state_q     <= ST_ACCESS;
              ram_en_q    <= 1'b1;
              ram_we_q    <= req_we;
              ram_addr_q  <= ram_addr_d;
              ram_sel_q   <= sel_full[LANES-1:0];
              ram_wdata_q <= ram_wdata_d;
            end
          end
        end
        ST_ACCESS: begin
          // ram_* stay frozen until the RAM acknowledges.
          if (ram_ack) begin
            state_q      <= ST_RESP;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ram_we_q ? '0 : ld_data;
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign stall      = (state_q == ST_IDLE && req_valid) || (state_q == ST_ACCESS);
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_sel    = ram_sel_q;
  assign ram_wdata  = ram_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: one 32-bit and one 64-bit instance, random plus directed accesses.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;
  bit done [2];

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          dly;
    bit          abort;
    bit          trap;
    int          e_cyc;
    logic [31:0] e_addr;
    logic [7:0]  e_sel;
    logic [63:0] e_wdata;
    logic [63:0] e_rdata;
    bit          e_mis;
  } item_t;

  task automatic chk(input int lane, input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL w%0d %s: got %h, expected %h", lane, name, act, exp);
    end
  endtask

  task automatic fail_now(input int lane, input string name);
    vectors++;
    miscompares++;
    $display("FAIL w%0d %s: event missing or unexpected", lane, name);
  endtask

  function automatic item_t mk(input bit we, input logic [1:0] size, input bit sgn, input logic [31:0] addr,
                               input logic [63:0] wdata, input logic [63:0] rdata, input int dly, input bit abort);
    item_t r;
    r = '{default: '0};
    r.we = we; r.size = size; r.sgn = sgn; r.addr = addr;
    r.wdata = wdata; r.rdata = rdata; r.dly = dly; r.abort = abort;
    return r;
  endfunction

  // Reference: byte-array view of the RAM word; lanes = bytes per RAM word.
  function automatic item_t model(input item_t it, input int lanes);
    item_t r;
    int sz, bytes, off, off_a;
    logic [7:0] fill;
    r = it;
    sz = int'(it.size);
    if (lanes == 4 && sz == 3) sz = 2;
    bytes = 1 << sz;
    off   = int'(it.addr % 32'(lanes));
    off_a = off - (off % bytes);
    r.trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    r.trap = (off != off_a);
`endif
    r.e_addr  = it.addr / 32'(lanes);
    r.e_sel   = '0;
    r.e_wdata = '0;
    r.e_rdata = '0;
    for (int j = 0; j < bytes; j++) r.e_sel[off_a + j] = 1'b1;
    for (int j = off_a; j < lanes; j++) r.e_wdata[8*j +: 8] = it.wdata[8*(j - off_a) +: 8];
    if (!it.we && !r.trap) begin
      fill = (it.sgn && it.rdata[8*(off_a + bytes) - 1]) ? 8'hFF : 8'h00;
      for (int j = 0; j < lanes; j++)
        r.e_rdata[8*j +: 8] = (j < bytes) ? it.rdata[8*(off_a + j) +: 8] : fill;
    end
    r.e_mis = r.trap;
    return r;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int DW = (gi == 0) ? 32 : 64;
    localparam int LN = DW / 8;

    logic          rst, req_valid, req_ready, req_we, req_signed;
    logic [1:0]    req_size;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata, ram_wdata, ram_rdata, resp_rdata;
    logic          ram_en, ram_we, ram_ack, resp_valid, stall, misalign;
    logic [31:0]   ram_addr;
    logic [LN-1:0] ram_sel;
    item_t         ram_q[$];
    item_t         resp_q[$];

    mem_access_unit #(.ADDR_BITS(32), .DATA_BITS(DW)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_sel    (ram_sel),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .ram_ack    (ram_ack),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .stall      (stall),
      .misalign   (misalign)
    );

    initial begin : drv
      item_t plan[$];
      item_t it;
      int t;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;

      if (DW == 32) begin
        plan.push_back(mk(1, 2'd0, 0, 32'h103, 64'hAB, 64'h0, 0, 0));
        plan.push_back(mk(0, 2'd1, 1, 32'h206, 64'h0, 64'h8001_1234, 0, 0));
        plan.push_back(mk(0, 2'd1, 0, 32'h206, 64'h0, 64'h8001_1234, 0, 0));
        plan.push_back(mk(0, 2'd2, 1, 32'h100, 64'h0, 64'h89AB_CDEF, 3, 0));
        plan.push_back(mk(0, 2'd2, 0, 32'h102, 64'h0, 64'h1234_5678, 0, 0));
        plan.push_back(mk(0, 2'd2, 0, 32'h300, 64'h0, 64'h55, 10, 1));
        plan.push_back(mk(1, 2'd2, 0, 32'h304, 64'hCAFE_F00D, 64'h0, 1, 0));
      end else begin
        plan.push_back(mk(1, 2'd2, 0, 32'h14, 64'hDEAD_BEEF, 64'h0, 0, 0));
        plan.push_back(mk(0, 2'd3, 1, 32'h18, 64'h0, 64'hF000_0000_0000_0001, 2, 0));
        plan.push_back(mk(0, 2'd0, 1, 32'h1F, 64'h0, 64'h8000_0000_0000_0000, 0, 0));
      end
      repeat (150)
        plan.push_back(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          $urandom, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3), 0));

      repeat (2) @(negedge clk);
      chk(DW, "rst_ram_en", 64'(ram_en), 64'd0);
      chk(DW, "rst_ram_we", 64'(ram_we), 64'd0);
      chk(DW, "rst_ram_sel", 64'(ram_sel), 64'd0);
      chk(DW, "rst_ram_addr", 64'(ram_addr), 64'd0);
      chk(DW, "rst_ram_wdata", 64'(ram_wdata), 64'd0);
      chk(DW, "rst_resp_valid", 64'(resp_valid), 64'd0);
      chk(DW, "rst_resp_rdata", 64'(resp_rdata), 64'd0);
      chk(DW, "rst_misalign", 64'(misalign), 64'd0);
      chk(DW, "rst_req_ready", 64'(req_ready), 64'd1);
      chk(DW, "rst_stall_idle", 64'(stall), 64'd0);
      req_valid = 1'b1;
      #1 chk(DW, "rst_stall_req", 64'(stall), 64'd1);
      @(negedge clk);
      chk(DW, "rst_wins_ram_en", 64'(ram_en), 64'd0);
      chk(DW, "rst_wins_ready", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      rst = 1'b0;

      foreach (plan[k]) begin
        it = model(plan[k], LN);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        t = 0;
        while (req_ready !== 1'b1 && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (req_ready !== 1'b1) begin
          fail_now(DW, "ready_timeout");
          break;
        end
        it.e_cyc   = cyc + (it.trap ? 1 : 2 + it.dly);
        req_valid  = 1'b1;
        req_we     = it.we;
        req_size   = it.size;
        req_signed = it.sgn;
        req_addr   = it.addr;
        req_wdata  = it.wdata[DW-1:0];
        if (!it.trap) ram_q.push_back(it);
        if (!it.abort) resp_q.push_back(it);
        #1 chk(DW, "stall_on_req", 64'(stall), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = DW'({$urandom, $urandom});
        if (it.abort) begin
          @(negedge clk);
          rst = 1'b1;
          @(negedge clk);
          chk(DW, "abort_ram_en", 64'(ram_en), 64'd0);
          chk(DW, "abort_ram_sel", 64'(ram_sel), 64'd0);
          chk(DW, "abort_ram_addr", 64'(ram_addr), 64'd0);
          chk(DW, "abort_ram_wdata", 64'(ram_wdata), 64'd0);
          chk(DW, "abort_resp_valid", 64'(resp_valid), 64'd0);
          chk(DW, "abort_req_ready", 64'(req_ready), 64'd1);
          ram_q.delete();
          rst = 1'b0;
        end
      end

      t = 0;
      while ((resp_q.size() != 0 || ram_q.size() != 0) && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (resp_q.size() != 0 || ram_q.size() != 0) fail_now(DW, "drain_timeout");
      repeat (3) @(negedge clk);
      done[gi] = 1'b1;
    end

    initial begin : rsp
      int cnt;
      cnt = 0;
      ram_ack = 1'b0;
      ram_rdata = '0;
      forever begin
        @(negedge clk);
        ram_ack = 1'b0;
        if (ram_en === 1'b1) begin
          if (ram_q.size() == 0) begin
            fail_now(DW, "unexpected_ram_en");
          end else begin
            chk(DW, "ram_we", 64'(ram_we), 64'(ram_q[0].we));
            chk(DW, "ram_addr", 64'(ram_addr), 64'(ram_q[0].e_addr));
            chk(DW, "ram_sel", 64'(ram_sel), 64'(ram_q[0].e_sel[LN-1:0]));
            chk(DW, "ram_wdata", 64'(ram_wdata), 64'(ram_q[0].e_wdata[DW-1:0]));
            chk(DW, "stall_access", 64'(stall), 64'd1);
            if (cnt >= ram_q[0].dly) begin
              ram_ack   = 1'b1;
              ram_rdata = ram_q[0].rdata[DW-1:0];
              void'(ram_q.pop_front());
              cnt = 0;
            end else begin
              cnt++;
              ram_rdata = DW'({$urandom, $urandom});
            end
          end
        end else begin
          cnt = 0;
          ram_ack   = ($urandom_range(0, 3) == 0);
          ram_rdata = DW'({$urandom, $urandom});
        end
      end
    end

    initial begin : mon
      item_t e;
      int n;
      n = 0;
      forever begin
        @(negedge clk);
        if (resp_valid === 1'b1) begin
          if (resp_q.size() == 0) begin
            fail_now(DW, "unexpected_resp_valid");
          end else begin
            e = resp_q.pop_front();
            chk(DW, "resp_rdata", 64'(resp_rdata), e.e_rdata);
            chk(DW, "misalign", 64'(misalign), 64'(e.e_mis));
            chk(DW, "resp_cycle", 64'(cyc), 64'(e.e_cyc));
            chk(DW, "stall_resp", 64'(stall), 64'd0);
            chk(DW, "ready_resp", 64'(req_ready), 64'd0);
            $display("w%0d txn %0d we=%0d sz=%0d addr=%h rdata=%h mis=%0d",
                     DW, n, e.we, e.size, e.addr, resp_rdata, misalign);
            n++;
          end
        end
      end
    end
  end

  initial begin : fin
    int t;
    t = 0;
    while (!(done[0] && done[1]) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (!(done[0] && done[1])) begin
      vectors++;
      miscompares++;
      $display("FAIL global_timeout: done=%0d%0d, expected 11", done[0], done[1]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
